acc_stream_ctrl: RTL and testbench
==================================

Name: acc_stream_ctrl

Overview:
Host-side initiator for the matrix-multiply accelerator.
- Receives operand elements over a valid/ready byte stream and packs them row-major into the accelerator's A and B operand buffers.
- Pulses the accelerator start, waits for its done, captures the result matrix, and streams the results back out over a valid/ready stream.
- Sits between the SoC stream/DMA fabric and the accelerator top.

Parameters:
- dat_size, 8, element width in bits (operands and results).
- mat_size, 2, matrix dimension; N = mat_size*mat_size elements per matrix.
- TIMEOUT_CYCLES, 1024, watchdog limit for the WAIT state (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an input element.
- in_data  in  dat_size  input element.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts a result element.
- out_data  out  dat_size  result element.
- acc_start  out  1  start pulse to the accelerator.
- acc_done  in  1  accelerator done (level).
- acc_in_A  out  [N-1:0][dat_size]  packed A operand buffer, registered.
- acc_in_B  out  [N-1:0][dat_size]  packed B operand buffer, registered.
- acc_out  in  [N-1:0][dat_size]  accelerator result matrix.
- busy  out  1  high in every state except LOAD_A with idx=0.
- frame_done  out  1  one-cycle pulse when the last result element is accepted.
- timeout_err  out  1  sticky watchdog flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, any state):
  - state=LOAD_A, idx=0.
  - acc_in_A, acc_in_B and the result register all zero.
  - in_ready=1, out_valid=0, acc_start=0, frame_done=0, timeout_err=0, out_data=0.
- FSM states: LOAD_A, LOAD_B, START, WAIT, DRAIN.
- Element index idx: width clog2(N), minimum 1 bit.
- LOAD_A:
  - in_ready=1.
  - On in_valid&&in_ready: acc_in_A[idx] <= in_data.
  - idx==N-1 -> idx=0, go to LOAD_B; otherwise idx++.
- LOAD_B: same as LOAD_A but writes acc_in_B[idx]; last element goes to START.
- START:
  - acc_start=1 for exactly one cycle, in_ready=0.
  - Next state is WAIT unconditionally; acc_done is ignored in START.
- WAIT:
  - acc_start=0.
  - On the first cycle with acc_done=1: result <= acc_out (all N elements, same edge), go to DRAIN with idx=0.
  - The minimum start-to-capture latency is 2 cycles.
- DRAIN:
  - out_valid=1, out_data=result[idx], registered from state/idx.
  - out_data is held stable while out_valid && !out_ready.
  - On out_ready: idx++.
  - At idx==N-1 with out_ready: frame_done=1 that cycle, go to LOAD_A with idx=0.
- Operand buffers hold their values after START, so the accelerator sees stable inputs through WAIT and DRAIN. They are overwritten only by the next frame's loads.
- in_ready=0 in START, WAIT and DRAIN. An in_valid asserted then is stalled, not dropped.
- Back-to-back frames: the next cycle after the frame_done cycle accepts input element 0 of the new frame.
- Throughput while loading is one element per cycle. A full frame with no stalls takes 2N + 1 (START) + ≥1 (WAIT) + N cycles.

Optional Feature:
- Macro: ACC_STREAM_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with acc_done still 0, set timeout_err=1 (sticky until rst) and load result with all zeros.
  - Then go to DRAIN, so the host still receives N zero elements and frame_done.
- Undefined:
  - No counter is built and timeout_err is tied 0.
  - WAIT lasts indefinitely until acc_done.

Test Plan:
1. Basic frame: mat_size=2, stream A=1,2,3,4 and B=5,6,7,8. Mock accelerator returns row-major product 19,22,43,50 with done 3 cycles after start -> one acc_start pulse after the 8th accepted element, out_data sequence 19,22,43,50, one frame_done, busy low afterwards.
2. Backpressure: repeat case 1 with out_ready toggled 1,0,0,1,... -> each out_data held stable while stalled, no element lost or duplicated, frame_done coincident with acceptance of 50.
3. Input stall: in_valid gaps of 0-3 cycles while loading, plus in_valid held high during WAIT -> acc_in_A/acc_in_B exactly 1,2,3,4 / 5,6,7,8; in_ready=0 from START until the frame_done cycle.
4. Stale done: acc_done held at 1 through LOAD and START -> capture occurs in the first WAIT cycle (2 cycles after acc_start), not earlier.
5. Reset mid-operation: assert rst during DRAIN after 2 elements are accepted -> out_valid=0 and buffers zero immediately (asynchronous); a following full frame behaves exactly as case 1.
6. With ACC_STREAM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, acc_done never asserted -> timeout_err=1 after 16 WAIT cycles, outputs 0,0,0,0, frame_done pulses, timeout_err remains 1 on the next frame.

Source files
------------

// File: rtl/acc_stream_ctrl_if.sv
// Valid/ready element streams between the SoC fabric and acc_stream_ctrl.
// slave is the controller side; master is the fabric (or bench) side.
interface acc_stream_ctrl_if #(
   parameter int dat_size = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [dat_size-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [dat_size-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/acc_stream_ctrl.sv
// Host-side initiator: packs A/B operands from a stream, runs the accelerator, streams results back.
// Optional WAIT-state watchdog is built when ACC_STREAM_CTRL_TIMEOUT_EN is defined.
module acc_stream_ctrl #(
   parameter int dat_size       = 8,
   parameter int mat_size       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                       clk,
   input  logic                                       rst,
   acc_stream_ctrl_if.slave                           strm,
   output logic                                       acc_start,
   input  logic                                       acc_done,
   output logic [mat_size*mat_size-1:0][dat_size-1:0] acc_in_A,
   output logic [mat_size*mat_size-1:0][dat_size-1:0] acc_in_B,
   input  logic [mat_size*mat_size-1:0][dat_size-1:0] acc_out,
   output logic                                       busy,
   output logic                                       frame_done,
   output logic                                       timeout_err
);
   localparam int N     = mat_size * mat_size;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, DRAIN} state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic [IDX_W-1:0]           idx;
   logic [IDX_W-1:0]           idx_nxt;
   logic [N-1:0][dat_size-1:0] result;
   logic                       wr_a;
   logic                       wr_b;
   logic                       cap;
   logic                       cap_zero;
   logic                       wd_expire;
   logic                       idx_last;

   assign idx_last      = (idx == IDX_LAST);
   assign busy          = !((state == LOAD_A) && (idx == '0));
   assign strm.out_data = result[idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOAD_A;
         idx      <= '0;
         acc_in_A <= '0;
         acc_in_B <= '0;
         result   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (wr_a) acc_in_A[idx] <= strm.in_data;
         if (wr_b) acc_in_B[idx] <= strm.in_data;
         // Whole matrix is captured on one edge; a watchdog expiry substitutes zeros.
         if (cap)           result <= acc_out;
         else if (cap_zero) result <= '0;
      end
   end

   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      wr_a           = 1'b0;
      wr_b           = 1'b0;
      cap            = 1'b0;
      cap_zero       = 1'b0;
      acc_start      = 1'b0;
      frame_done     = 1'b0;
      strm.in_ready  = 1'b0;
      strm.out_valid = 1'b0;
      case (state)
         LOAD_A: begin
            strm.in_ready = 1'b1;
            if (strm.in_valid) begin
               wr_a = 1'b1;
               if (idx_last) begin
                  idx_nxt   = '0;
                  state_nxt = LOAD_B;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         LOAD_B: begin
            strm.in_ready = 1'b1;
            if (strm.in_valid) begin
               wr_b = 1'b1;
               if (idx_last) begin
                  idx_nxt   = '0;
                  state_nxt = START;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         START: begin
            // A done level left over from the previous frame must not be taken here.
            acc_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (acc_done) begin
               cap       = 1'b1;
               idx_nxt   = '0;
               state_nxt = DRAIN;
            end else if (wd_expire) begin
               cap_zero  = 1'b1;
               idx_nxt   = '0;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            strm.out_valid = 1'b1;
            if (strm.out_ready) begin
               if (idx_last) begin
                  frame_done = 1'b1;
                  idx_nxt    = '0;
                  state_nxt  = LOAD_A;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            idx_nxt   = '0;
            state_nxt = LOAD_A;
         end
      endcase
   end

`ifdef ACC_STREAM_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle without done.
   assign wd_expire   = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == START)     wd_cnt <= '0;
         else if (state == WAIT) wd_cnt <= wd_cnt + WD_W'(1);
         if ((state == WAIT) && !acc_done && wd_expire) timeout_q <= 1'b1;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_stream_ctrl.sv
// Self-checking bench for acc_stream_ctrl: randomized frames against a matrix-product model,
// with a mock accelerator whose done timing is selectable (delayed, stale-high, never).
`timescale 1ns/1ps
module tb_acc_stream_ctrl;
   localparam int DW = 8;
   localparam int MS = 2;
   localparam int N  = MS * MS;
   localparam int TO = 16;

   typedef logic [DW-1:0] elem_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 acc_start;
   logic                 acc_done;
   logic                 busy;
   logic                 frame_done;
   logic                 timeout_err;
   logic [N-1:0][DW-1:0] acc_in_A;
   logic [N-1:0][DW-1:0] acc_in_B;
   logic [N-1:0][DW-1:0] acc_out;

   acc_stream_ctrl_if #(.dat_size(DW)) strm ();

   acc_stream_ctrl #(.dat_size(DW), .mat_size(MS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .strm(strm), .acc_start(acc_start), .acc_done(acc_done),
      .acc_in_A(acc_in_A), .acc_in_B(acc_in_B), .acc_out(acc_out), .busy(busy),
      .frame_done(frame_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   elem_t exp_c [N];
   int    mock_mode  = 0;
   int    mock_delay = 3;
   int    mcnt       = 0;

   elem_t                got[$];
   int                   fd_cnt, fd_on_last, fd_cyc, stall_viol, inrdy_viol;
   int                   start_cnt, start_cyc, first_ov_cyc, first_acc_cyc, last_acc_cyc, coll_done;
   logic [N-1:0][DW-1:0] a_snap, b_snap;

   function automatic void matmul(input elem_t a[N], input elem_t b[N], output elem_t c[N]);
      for (int i = 0; i < MS; i++) begin
         for (int j = 0; j < MS; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < MS; k++) s += int'(a[i*MS+k]) * int'(b[k*MS+j]);
            c[i*MS+j] = elem_t'(s);
         end
      end
   endfunction

   // Mock accelerator: 0 = done mock_delay cycles after start, 1 = done stuck high, 2 = never done.
   initial begin
      acc_done = 1'b0;
      acc_out  = '0;
      forever begin
         @(negedge clk);
         if (mock_mode == 1) begin
            acc_done = 1'b1;
            for (int i = 0; i < N; i++) acc_out[i] = exp_c[i];
         end else if (mock_mode == 2) begin
            acc_done = 1'b0;
            mcnt     = 0;
         end else if (acc_start) begin
            acc_done = 1'b0;
            mcnt     = mock_delay;
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               acc_done = 1'b1;
               for (int i = 0; i < N; i++) acc_out[i] = exp_c[i];
            end
         end
      end
   end

   task automatic drive(input elem_t a[N], input elem_t b[N], input int max_gap, input bit hold);
      elem_t seq[2*N];
      for (int i = 0; i < N; i++) begin
         seq[i]   = a[i];
         seq[N+i] = b[i];
      end
      for (int i = 0; i < 2*N; i++) begin
         int t;
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         strm.in_valid = 1'b1;
         strm.in_data  = seq[i];
         t = 0;
         while (!strm.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL drive_accept[%0d]: in_ready=0 expected 1 within 2000 cycles", i);
         end
         if (i == 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
         @(negedge clk);
         strm.in_valid = 1'b0;
      end
      if (hold) begin
         int t;
         t = 0;
         strm.in_valid = 1'b1;
         strm.in_data  = 8'hEE;
         while (!strm.out_valid && t < 2000) begin
            @(negedge clk);
            t++;
         end
         strm.in_valid = 1'b0;
      end
   endtask

   task automatic collect(input int n, input int rdy_mode);
      int    k, t;
      bit    stall;
      elem_t held;
      k = 0; t = 0; stall = 1'b0; held = '0;
      while (got.size() < n && t < 3000) begin
         @(negedge clk);
         case (rdy_mode)
            0:       strm.out_ready = 1'b1;
            1:       strm.out_ready = (k % 3 == 0);
            default: strm.out_ready = 1'($urandom_range(1, 0));
         endcase
         k++; t++;
         #1;
         if (stall && (!strm.out_valid || strm.out_data !== held)) stall_viol++;
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (strm.out_valid && strm.out_ready) begin
            got.push_back(strm.out_data);
            if (got.size() == n && frame_done) fd_on_last = 1;
         end
         stall = strm.out_valid && !strm.out_ready;
         held  = strm.out_data;
      end
      coll_done = 1;
   endtask

   task automatic monitor();
      bit seen;
      int t;
      seen = 1'b0; t = 0;
      while (!coll_done && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
         if (acc_start) begin
            start_cnt++;
            if (!seen) begin
               seen      = 1'b1;
               start_cyc = cyc;
               a_snap    = acc_in_A;
               b_snap    = acc_in_B;
            end
         end
         if (seen && strm.in_ready) inrdy_viol++;
         if (strm.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
         if (frame_done) break;
      end
   endtask

   task automatic run_frame(input elem_t a[N], input elem_t b[N], input int max_gap,
                            input int rdy_mode, input bit hold, input int n_coll);
      matmul(a, b, exp_c);
      got.delete();
      fd_cnt = 0; fd_on_last = 0; fd_cyc = -1; stall_viol = 0; inrdy_viol = 0;
      start_cnt = 0; start_cyc = -1; first_ov_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
      coll_done = 0;
      fork
         drive(a, b, max_gap, hold);
         collect(n_coll, rdy_mode);
         monitor();
      join
   endtask

   task automatic test_reset();
      #1;
      checks++; if (strm.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", strm.in_ready); end
      checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", strm.out_valid); end
      checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start: got %b expected 0", acc_start); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      checks++; if (strm.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", strm.out_data); end
      checks++; if (acc_in_A !== '0 || acc_in_B !== '0) begin errors++; $display("FAIL reset_buffers: got A=%h B=%h expected 0", acc_in_A, acc_in_B); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      elem_t a[N]     = '{1, 2, 3, 4};
      elem_t b[N]     = '{5, 6, 7, 8};
      elem_t ref_c[N] = '{19, 22, 43, 50};
      mock_mode = 0; mock_delay = 3;
      run_frame(a, b, 0, 0, 1'b0, N);
      checks++; if (start_cnt !== 1) begin errors++; $display("FAIL basic_start_cnt: got %0d expected 1", start_cnt); end
      checks++; if (start_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL basic_start_cyc: got %0d expected %0d", start_cyc, last_acc_cyc + 1); end
      checks++; if (first_ov_cyc - start_cyc !== mock_delay + 1) begin errors++; $display("FAIL basic_capture_lat: got %0d expected %0d", first_ov_cyc - start_cyc, mock_delay + 1); end
      for (int i = 0; i < N; i++) begin
         checks++; if (a_snap[i] !== a[i] || b_snap[i] !== b[i]) begin errors++; $display("FAIL basic_operand[%0d]: got A=%0d B=%0d expected A=%0d B=%0d", i, a_snap[i], b_snap[i], a[i], b[i]); end
      end
      checks++; if (got.size() !== N) begin errors++; $display("FAIL basic_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== ref_c[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], ref_c[i]); end
      end
      checks++; if (fd_cnt !== 1 || fd_on_last !== 1) begin errors++; $display("FAIL basic_frame_done: got count=%0d on_last=%0d expected 1/1", fd_cnt, fd_on_last); end
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || strm.in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: got busy=%b in_ready=%b expected 0/1", busy, strm.in_ready); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL basic_timeout_err: got %b expected 0", timeout_err); end
   endtask

   task automatic test_backpressure();
      elem_t a[N]     = '{1, 2, 3, 4};
      elem_t b[N]     = '{5, 6, 7, 8};
      elem_t ref_c[N] = '{19, 22, 43, 50};
      mock_mode = 0; mock_delay = 3;
      run_frame(a, b, 0, 1, 1'b0, N);
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable stalls expected 0", stall_viol); end
      checks++; if (got.size() !== N) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== ref_c[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got[i], ref_c[i]); end
      end
      checks++; if (fd_cnt !== 1 || fd_on_last !== 1) begin errors++; $display("FAIL bp_frame_done: got count=%0d on_last=%0d expected 1/1", fd_cnt, fd_on_last); end
   endtask

   task automatic test_input_stall();
      elem_t a[N] = '{1, 2, 3, 4};
      elem_t b[N] = '{5, 6, 7, 8};
      mock_mode = 0; mock_delay = 4;
      run_frame(a, b, 3, 0, 1'b1, N);
      for (int i = 0; i < N; i++) begin
         checks++; if (a_snap[i] !== a[i] || b_snap[i] !== b[i]) begin errors++; $display("FAIL stall_operand[%0d]: got A=%0d B=%0d expected A=%0d B=%0d", i, a_snap[i], b_snap[i], a[i], b[i]); end
         checks++; if (acc_in_A[i] !== a[i] || acc_in_B[i] !== b[i]) begin errors++; $display("FAIL stall_operand_held[%0d]: got A=%0d B=%0d expected A=%0d B=%0d", i, acc_in_A[i], acc_in_B[i], a[i], b[i]); end
      end
      checks++; if (inrdy_viol !== 0) begin errors++; $display("FAIL stall_in_ready: got %0d cycles high after start expected 0", inrdy_viol); end
      checks++; if (got.size() !== N) begin errors++; $display("FAIL stall_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_c[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got[i], exp_c[i]); end
      end
   endtask

   task automatic test_stale_done();
      elem_t a[N], b[N];
      for (int i = 0; i < N; i++) begin
         a[i] = elem_t'($urandom);
         b[i] = elem_t'($urandom);
      end
      mock_mode = 1;
      run_frame(a, b, 0, 0, 1'b0, N);
      mock_mode = 0;
      checks++; if (start_cnt !== 1) begin errors++; $display("FAIL stale_start_cnt: got %0d expected 1", start_cnt); end
      checks++; if (first_ov_cyc - start_cyc !== 2) begin errors++; $display("FAIL stale_capture_lat: got %0d expected 2", first_ov_cyc - start_cyc); end
      checks++; if (got.size() !== N) begin errors++; $display("FAIL stale_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_c[i]) begin errors++; $display("FAIL stale_data[%0d]: got %0d expected %0d", i, got[i], exp_c[i]); end
      end
   endtask

   task automatic test_reset_mid();
      elem_t a[N]     = '{1, 2, 3, 4};
      elem_t b[N]     = '{5, 6, 7, 8};
      elem_t ref_c[N] = '{19, 22, 43, 50};
      mock_mode = 0; mock_delay = 2;
      run_frame(a, b, 0, 0, 1'b0, 2);
      strm.out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", strm.out_valid); end
      checks++; if (acc_in_A !== '0 || acc_in_B !== '0) begin errors++; $display("FAIL rstmid_buffers: got A=%h B=%h expected 0", acc_in_A, acc_in_B); end
      checks++; if (busy !== 1'b0 || strm.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got busy=%b in_ready=%b expected 0/1", busy, strm.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      mock_delay = 3;
      run_frame(a, b, 0, 0, 1'b0, N);
      checks++; if (got.size() !== N) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== ref_c[i]) begin errors++; $display("FAIL rstmid_data[%0d]: got %0d expected %0d", i, got[i], ref_c[i]); end
      end
      checks++; if (fd_cnt !== 1 || fd_on_last !== 1) begin errors++; $display("FAIL rstmid_frame_done: got count=%0d on_last=%0d expected 1/1", fd_cnt, fd_on_last); end
   endtask

   task automatic test_back_to_back();
      elem_t a[N], b[N];
      int    prev_fd;
      mock_mode = 0; mock_delay = 1;
      prev_fd = -1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) begin
            a[i] = elem_t'($urandom);
            b[i] = elem_t'($urandom);
         end
         run_frame(a, b, 0, 0, 1'b0, N);
         if (f > 0) begin
            checks++; if (first_acc_cyc !== prev_fd + 1) begin errors++; $display("FAIL b2b_first_accept[%0d]: got cycle %0d expected %0d", f, first_acc_cyc, prev_fd + 1); end
         end
         checks++; if (got.size() !== N) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", f, got.size(), N); end
         for (int i = 0; i < N && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_c[i]) begin errors++; $display("FAIL b2b_data[%0d][%0d]: got %0d expected %0d", f, i, got[i], exp_c[i]); end
         end
         prev_fd = fd_cyc;
      end
   endtask

   task automatic test_random();
      elem_t a[N], b[N];
      mock_mode = 0;
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < N; i++) begin
            a[i] = elem_t'($urandom);
            b[i] = elem_t'($urandom);
         end
         mock_delay = $urandom_range(5, 1);
         run_frame(a, b, 3, 2, 1'($urandom_range(1, 0)), N);
         checks++; if (start_cnt !== 1 || inrdy_viol !== 0 || stall_viol !== 0) begin errors++; $display("FAIL rand_ctrl[%0d]: got starts=%0d in_ready_viol=%0d stall_viol=%0d expected 1/0/0", f, start_cnt, inrdy_viol, stall_viol); end
         for (int i = 0; i < N; i++) begin
            checks++; if (a_snap[i] !== a[i] || b_snap[i] !== b[i]) begin errors++; $display("FAIL rand_operand[%0d][%0d]: got A=%0d B=%0d expected A=%0d B=%0d", f, i, a_snap[i], b_snap[i], a[i], b[i]); end
         end
         checks++; if (got.size() !== N) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", f, got.size(), N); end
         for (int i = 0; i < N && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_c[i]) begin errors++; $display("FAIL rand_data[%0d][%0d]: got %0d expected %0d", f, i, got[i], exp_c[i]); end
         end
         checks++; if (fd_cnt !== 1 || fd_on_last !== 1) begin errors++; $display("FAIL rand_frame_done[%0d]: got count=%0d on_last=%0d expected 1/1", f, fd_cnt, fd_on_last); end
      end
   endtask

`ifdef ACC_STREAM_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      elem_t a[N], b[N];
      for (int i = 0; i < N; i++) begin
         a[i] = elem_t'($urandom);
         b[i] = elem_t'($urandom);
      end
      mock_mode = 2;
      run_frame(a, b, 0, 0, 1'b0, N);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
      checks++; if (first_ov_cyc - start_cyc !== TO + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", first_ov_cyc - start_cyc, TO + 1); end
      checks++; if (got.size() !== N) begin errors++; $display("FAIL to_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== 8'h00) begin errors++; $display("FAIL to_data[%0d]: got %0d expected 0", i, got[i]); end
      end
      checks++; if (fd_cnt !== 1 || fd_on_last !== 1) begin errors++; $display("FAIL to_frame_done: got count=%0d on_last=%0d expected 1/1", fd_cnt, fd_on_last); end
      mock_mode = 0; mock_delay = 3;
      run_frame(a, b, 0, 0, 1'b0, N);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
      for (int i = 0; i < N && i < got.size(); i++) begin
         checks++; if (got[i] !== exp_c[i]) begin errors++; $display("FAIL to_next_data[%0d]: got %0d expected %0d", i, got[i], exp_c[i]); end
      end
   endtask
`endif

   initial begin
      rst            = 1'b0;
      strm.in_valid  = 1'b0;
      strm.in_data   = '0;
      strm.out_ready = 1'b0;
      #2 rst = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_input_stall();
      test_stale_done();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef ACC_STREAM_CTRL_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
